ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  - RV32I instruction fetch unit. Owns the PC, issues in-order word fetches to instruction memory,
//    buffers returned words in a small queue and presents {instr, pc} to decode (imm_gen / decoder) with valid/ready.
//  - Takes branch/jump redirects from execute and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset release
//  FIFO_DEPTH  2              instruction queue entries (power of 2, >=2); also the max requests in flight
// PORTS
//  clk             in   1     core clock
//  rst_n           in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  word-aligned fetch address
//  imem_rsp_valid  in   1     response valid; in request order, no backpressure
//  imem_rsp_data   in   ILEN  fetched instruction word
//  redirect_valid  in   1     execute redirect (taken branch/JAL/JALR)
//  redirect_pc     in   XLEN  redirect target
//  id_valid        out  1     queue head valid
//  id_ready        in   1     decode consumes head
//  id_instr        out  ILEN  head instruction
//  id_pc           out  XLEN  head PC
//  id_misalign     out  1     head is an instruction-address-misaligned trap entry
// BEHAVIOUR
//  - Reset: state=BOOT, fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty.
//    Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=NOP (32'h0000_0013), id_pc=0, id_misalign=0.
//  - FSM: BOOT -> RUN after 1 cycle. RUN -> FLUSH on redirect with responses pending.
//    FLUSH -> RUN when drop_cnt reaches 0. Any state -> HALT on a misaligned redirect (macro only).
//    HALT -> RUN/FLUSH on the next aligned redirect.
//  - Credit: imem_req_valid = (RUN|FLUSH) & !redirect_valid & (count + outstanding < FIFO_DEPTH).
//    imem_req_addr = fetch_pc, held stable while valid & !ready.
//  - Request handshake (valid & ready): fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
//  - Response: outstanding -= 1.
//    - drop_cnt != 0: decrement drop_cnt; do not enqueue.
//    - otherwise: push {imem_rsp_data, rsp_pc, 0}; rsp_pc += 4.
//    - A push on a full queue cannot occur by credit; the verification bench asserts this.
//  - Decode side: id_* = queue head; id_valid = !empty. Pop on id_valid & id_ready. Push+pop in one cycle keeps count.
//  - Redirect (priority over all events in that cycle):
//    - queue flushed, including any same-cycle pop/push; fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
//    - drop_cnt = outstanding - (imem_rsp_valid ? 1 : 0); a same-cycle response is itself dropped.
//    - no request issued that cycle.
//  - Latency: request accepted in cycle N, response in cycle M -> id_valid in cycle M+1 (registered queue).
//  - Reset mid-operation: all state cleared asynchronously; responses arriving after release are not expected
//    (memory shares rst_n).
// CONFIGURATION
//  - IFU_MISALIGN_TRAP_EN defined: redirect_pc[1:0] != 0 -> no fetch.
//    - enqueue one entry {NOP, redirect_pc, id_misalign=1}; state=HALT.
//    - issue no requests until the next redirect.
//  - Undefined: redirect_pc[1:0] ignored (target forced word-aligned); id_misalign tied 0; HALT unreachable.
// STRUCTURE
//  - rv32i_pkg additions: NOP_INSTR constant; ifu_state_e {BOOT, RUN, FLUSH, HALT};
//    fetch_entry_t {instr[ILEN], pc[XLEN], misalign}. XLEN/ILEN from rv32i_pkg.
//  - Sub-module ifu_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty/full.
//    Flush has priority over push/pop.
//  - ifu_fetch holds FSM, PC/credit/drop counters.
// TESTING
//  1. RESET_PC=32'h100, imem_req_ready=1, 1-cycle memory
//     -> addrs 0x100,0x104,...; first id_pc=0x100, id_instr=rsp data; id_valid 1 cycle after rsp.
//  2. id_ready=0, FIFO_DEPTH=2 -> exactly 2 requests accepted then imem_req_valid=0;
//     one pop -> exactly one more request.
//  3. imem_req_ready=0 for 3 cycles -> imem_req_addr stays 0x108 and valid stays high; no PC advance.
//  4. 2 outstanding, redirect_pc=0x200 -> next 2 responses dropped; first id_pc=0x200; state FLUSH -> RUN.
//  5. Redirect to 0x300 coincides with a response and an id pop -> queue empty next cycle; that response dropped;
//     drop_cnt = outstanding-1; next id_pc=0x300.
//  6. redirect_pc=0x202
//     - macro on: one entry id_misalign=1, id_pc=0x202, no further requests until redirect 0x400.
//     - macro off: fetch resumes at 0x200.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, the canonical NOP, and the fetch queue entry / fetch FSM types.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HALT
  } ifu_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch instruction queue: small synchronous FIFO of fetch entries.
// Flush wins over push/pop; an empty queue presents a NOP entry at PC 0.
module ifu_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted in
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head = '{instr: NOP_INSTR, pc: '0, misalign: 1'b0};
    if (!empty) head = mem[rd_ptr_q];
  end

endmodule

// File: rtl/ifu_fetch.sv
// RV32I fetch unit: PC, credit-limited in-order imem requests, redirect flush with stale-response dropping.
// Optional IFU_MISALIGN_TRAP_EN turns misaligned redirects into a single trap entry and halts fetch.
module ifu_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q, redirect_target;
  logic [CW-1:0]   outstanding_q, drop_cnt_q, drop_cnt_d, rsp_dec, fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty, fifo_full;
  logic            req_fire, rsp_push, trap_push, push, pop, redirect_misalign;
  fetch_entry_t    push_entry, head;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign rsp_dec         = CW'(imem_rsp_valid);
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding_q};

  assign imem_req_valid = ((state_q == RUN) || (state_q == FLUSH)) && !redirect_valid &&
                          !fifo_full && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_push = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
  assign push     = rsp_push | trap_push;
  assign pop      = id_valid & id_ready;

`ifdef IFU_MISALIGN_TRAP_EN
  logic            trap_pending_q;
  logic [XLEN-1:0] trap_pc_q;

  assign redirect_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign trap_push         = trap_pending_q & ~redirect_valid;
  assign push_entry        = trap_push ? '{instr: NOP_INSTR, pc: trap_pc_q, misalign: 1'b1}
                                       : '{instr: imem_rsp_data, pc: rsp_pc_q, misalign: 1'b0};

  // Trap entry is enqueued the cycle after the redirect, once the flush has cleared the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pending_q <= 1'b0;
      trap_pc_q      <= '0;
    end else if (redirect_valid) begin
      trap_pending_q <= redirect_misalign;
      trap_pc_q      <= redirect_pc;
    end else if (trap_pending_q) begin
      trap_pending_q <= 1'b0;
    end
  end
`else
  assign redirect_misalign = 1'b0;
  assign trap_push         = 1'b0;
  assign push_entry        = '{instr: imem_rsp_data, pc: rsp_pc_q, misalign: 1'b0};
`endif

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign id_valid    = ~fifo_empty;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_misalign = head.misalign;

  // A redirect's own same-cycle response is already counted out of drop_cnt
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = outstanding_q - rsp_dec;
      if (redirect_misalign)        state_d = HALT;
      else if (drop_cnt_d != '0)    state_d = FLUSH;
      else                          state_d = RUN;
    end else begin
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      case (state_q)
        BOOT:    state_d = RUN;
        FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      drop_cnt_q    <= drop_cnt_d;
      outstanding_q <= outstanding_q + CW'(req_fire) - rsp_dec;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_target;
        rsp_pc_q   <= redirect_target;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (rsp_push) rsp_pc_q   <= rsp_pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: 1-cycle memory model with optional stall, cycle-exact expectations.
module tb_ifu_fetch;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_misalign;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] pend[$];
  logic        mem_stall = 1'b0;
  logic        hs;
  logic [31:0] hs_addr;

  ifu_fetch #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_misalign    (id_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic idr, input logic rqr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = idr;
    imem_req_ready = rqr;
    #1;
  endtask

  // Advance one cycle; memory answers each accepted request in the following cycle unless stalled
  task automatic stepClock();
    checkOutput("push_on_full", 32'(dut.push & dut.fifo_full & ~dut.pop), 32'h0);
    hs      = imem_req_valid & imem_req_ready;
    hs_addr = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    if (hs) pend.push_back(hs_addr);
    if (!mem_stall && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h100);
    checkOutput("rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h13);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_misalign", 32'(id_misalign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // C0 BOOT
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("boot_req_valid", 32'(imem_req_valid), 32'h0);
    stepClock();
    // C1
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c1_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("c1_req_addr", imem_req_addr, 32'h100);
    stepClock();
    // C2
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c2_req_addr", imem_req_addr, 32'h104);
    checkOutput("c2_id_valid", 32'(id_valid), 32'h0);
    stepClock();
    // C3
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c3_id_valid", 32'(id_valid), 32'h1);
    checkOutput("c3_id_pc", id_pc, 32'h100);
    checkOutput("c3_id_instr", id_instr, 32'hC0DE_0100);
    checkOutput("c3_credit_block", 32'(imem_req_valid), 32'h0);
    checkOutput("c3_req_addr", imem_req_addr, 32'h108);
    stepClock();
    // C4: queue full, pop once
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("c4_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("c4_id_pc", id_pc, 32'h100);
    stepClock();
    // C5..C7: memory not ready
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h1);
      checkOutput("stall_req_addr", imem_req_addr, 32'h108);
      if (i == 0) checkOutput("c5_id_instr", id_instr, 32'hC0DE_0104);
      stepClock();
    end
    // C8
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c8_req_addr", imem_req_addr, 32'h108);
    stepClock();
    // C9: one pop bought exactly one request
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c9_req_valid", 32'(imem_req_valid), 32'h0);
    stepClock();
    // C10
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("c10_id_pc", id_pc, 32'h104);
    stepClock();
    // C11
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("c11_id_pc", id_pc, 32'h108);
    checkOutput("c11_req_addr", imem_req_addr, 32'h10C);
    mem_stall = 1'b1;
    stepClock();
    // C12
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c12_req_addr", imem_req_addr, 32'h110);
    stepClock();
    // C13: two outstanding, redirect to 0x200
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    checkOutput("c13_redir_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("c13_id_valid", 32'(id_valid), 32'h0);
    mem_stall = 1'b0;
    stepClock();
    // C14
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c14_state", 32'(dut.state_q), 32'(FLUSH));
    checkOutput("c14_req_valid", 32'(imem_req_valid), 32'h0);
    stepClock();
    // C15
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c15_req_addr", imem_req_addr, 32'h200);
    checkOutput("c15_id_valid", 32'(id_valid), 32'h0);
    stepClock();
    // C16
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c16_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("c16_dropped", 32'(id_valid), 32'h0);
    checkOutput("c16_req_addr", imem_req_addr, 32'h204);
    stepClock();
    // C17: redirect with same-cycle response and pop
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
    checkOutput("c17_id_pc", id_pc, 32'h200);
    checkOutput("c17_id_instr", id_instr, 32'hC0DE_0200);
    checkOutput("c17_rsp_present", 32'(imem_rsp_valid), 32'h1);
    stepClock();
    // C18
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c18_id_valid", 32'(id_valid), 32'h0);
    checkOutput("c18_drop_cnt", 32'(dut.drop_cnt_q), 32'h0);
    checkOutput("c18_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("c18_req_addr", imem_req_addr, 32'h300);
    stepClock();
    // C19
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    // C20
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("c20_id_pc", id_pc, 32'h300);
    checkOutput("c20_id_instr", id_instr, 32'hC0DE_0300);
    stepClock();
    // C21: misaligned redirect
    applyStimulus(1'b1, 32'h202, 1'b0, 1'b1);
    stepClock();
`ifdef IFU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_state", 32'(dut.state_q), 32'(HALT));
    checkOutput("t6_req_valid0", 32'(imem_req_valid), 32'h0);
    checkOutput("t6_id_valid0", 32'(id_valid), 32'h0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t6_id_valid1", 32'(id_valid), 32'h1);
    checkOutput("t6_id_pc", id_pc, 32'h202);
    checkOutput("t6_id_instr", id_instr, 32'h13);
    checkOutput("t6_id_misalign", 32'(id_misalign), 32'h1);
    checkOutput("t6_req_valid1", 32'(imem_req_valid), 32'h0);
    stepClock();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t6_halt_req", 32'(imem_req_valid), 32'h0);
      checkOutput("t6_halt_id", 32'(id_valid), 32'h0);
      stepClock();
    end
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_resume_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("t6_resume_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("t6_resume_addr", imem_req_addr, 32'h400);
`else
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("t6_id_valid0", 32'(id_valid), 32'h0);
    checkOutput("t6_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("t6_req_addr", imem_req_addr, 32'h200);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_id_valid1", 32'(id_valid), 32'h1);
    checkOutput("t6_id_pc", id_pc, 32'h200);
    checkOutput("t6_id_misalign", 32'(id_misalign), 32'h0);
`endif

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("mid_rst_req_addr", imem_req_addr, 32'h100);
    checkOutput("mid_rst_state", 32'(dut.state_q), 32'(BOOT));
    pend.delete();
    imem_rsp_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
